// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache backend types: the LR/SC reservation FSM states.
package bp_be_dcache_pkg;

    typedef enum logic [1:0] {
        e_lrsc_idle,
        e_lrsc_hold,
        e_lrsc_reserved
    } bp_be_lrsc_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p instead of wrapping.
module bsg_counter_clear_up #(
    parameter int max_val_p = 16,
    parameter int width_p   = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_o <= '0;
        end else if (up_i && (count_o != max_lp)) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/bp_be_dcache_lrsc_monitor.sv
// Single-hart LR/SC reservation tracker: judges SC success and refuses
// invalidations to the reserved line for a short window after each LR.
module bp_be_dcache_lrsc_monitor
    import bp_be_dcache_pkg::*;
#(
    parameter int paddr_width_p        = 40,
    parameter int block_offset_width_p = 6,
    parameter int lr_hold_p            = 16
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          flush_i,
    input  logic                                          v_i,
    input  logic                                          lr_op_i,
    input  logic                                          sc_op_i,
    input  logic                                          store_op_i,
    input  logic [paddr_width_p-1:0]                      paddr_i,
    input  logic                                          inv_v_i,
    input  logic [paddr_width_p-1:0]                      inv_addr_i,
    output logic                                          inv_yumi_o,
    output logic                                          sc_v_o,
    output logic                                          sc_success_o,
    output logic                                          reservation_v_o,
    output logic [paddr_width_p-block_offset_width_p-1:0] reservation_addr_o
);

    localparam int line_width_lp = paddr_width_p - block_offset_width_p;
    localparam int cnt_width_lp  = (lr_hold_p > 0) ? $clog2(lr_hold_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0] hold_last_lp =
        (lr_hold_p > 0) ? cnt_width_lp'(lr_hold_p - 1) : '0;

    bp_be_lrsc_state_e state_r, state_n;
    logic [line_width_lp-1:0] line_r, line_n;
    logic sc_v_r, sc_v_n, sc_success_r, sc_success_n;
    logic [cnt_width_lp-1:0] hold_cnt;

    logic [line_width_lp-1:0] op_line, inv_line;
    logic commit, lr_commit, sc_commit, st_commit;
    logic match_inv, match_op, in_hold, in_reserved;
    logic unused_offset_bits;

    assign op_line  = paddr_i[paddr_width_p-1:block_offset_width_p];
    assign inv_line = inv_addr_i[paddr_width_p-1:block_offset_width_p];
    assign unused_offset_bits = ^{paddr_i[block_offset_width_p-1:0],
                                  inv_addr_i[block_offset_width_p-1:0]};

    assign commit    = v_i & ~flush_i;
    assign lr_commit = commit & lr_op_i;
    assign sc_commit = commit & sc_op_i;
    assign st_commit = commit & store_op_i & ~sc_op_i;

    assign match_inv   = inv_v_i & (inv_line == line_r);
    assign match_op    = (op_line == line_r);
    assign in_hold     = (state_r == e_lrsc_hold);
    assign in_reserved = (state_r == e_lrsc_reserved);

    // The only refusal: a matching invalidation while the post-LR window is open.
    assign inv_yumi_o = inv_v_i & ~(in_hold & match_inv);

    bsg_counter_clear_up #(
        .max_val_p (lr_hold_p),
        .width_p   (cnt_width_lp)
    ) hold_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (lr_commit | flush_i),
        .up_i    (in_hold),
        .count_o (hold_cnt)
    );

    always_comb begin
        state_n      = state_r;
        line_n       = line_r;
        sc_v_n       = 1'b0;
        sc_success_n = 1'b0;
        if (flush_i) begin
            state_n = e_lrsc_idle;
        end else if (lr_commit) begin
            line_n  = op_line;
            state_n = (lr_hold_p > 0) ? e_lrsc_hold : e_lrsc_reserved;
        end else if (sc_commit) begin
            // An invalidation accepted in the same cycle beats the SC.
            sc_v_n       = 1'b1;
            sc_success_n = (state_r != e_lrsc_idle) & match_op
                         & ~(in_reserved & match_inv);
            state_n      = e_lrsc_idle;
        end else if (st_commit && match_op && (state_r != e_lrsc_idle)) begin
            state_n = e_lrsc_idle;
        end else if (in_reserved && match_inv) begin
            state_n = e_lrsc_idle;
        end else if (in_hold && (hold_cnt == hold_last_lp)) begin
            state_n = e_lrsc_reserved;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_lrsc_idle;
            line_r       <= '0;
            sc_v_r       <= 1'b0;
            sc_success_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            line_r       <= line_n;
            sc_v_r       <= sc_v_n;
            sc_success_r <= sc_success_n;
        end
    end

    assign sc_v_o             = sc_v_r;
    assign sc_success_o       = sc_success_r;
    assign reservation_v_o    = (state_r != e_lrsc_idle);
    assign reservation_addr_o = line_r;

endmodule

// File: tb/tb_bp_be_dcache_lrsc_monitor.sv
// Bench for the LR/SC monitor: vector table plus hand sequences, SC results
// scoreboarded through an expected queue.
module tb_bp_be_dcache_lrsc_monitor;

    localparam int PW = 40;
    localparam int LW = 34;

    typedef struct {
        logic          v, lr, sc, st, fl;
        logic [PW-1:0] pa;
        logic          iv;
        logic [PW-1:0] ia;
        int            reps;
        logic          exp_yumi;
        logic          exp_resv;
        logic [LW-1:0] exp_addr;
        logic          exp_succ;
    } vec_t;

    logic clk = 1'b0;
    logic reset_i, flush_i, v_i, lr_op_i, sc_op_i, store_op_i, inv_v_i;
    logic [PW-1:0] paddr_i, inv_addr_i;

    logic a_yumi, a_sc_v, a_sc_succ, a_resv;
    logic [LW-1:0] a_addr;
    logic b_yumi, b_sc_v, b_sc_succ, b_resv;
    logic [LW-1:0] b_addr;

    int n_pass = 0;
    int n_total = 0;
    logic exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    bp_be_dcache_lrsc_monitor #(.paddr_width_p(PW), .block_offset_width_p(6), .lr_hold_p(16)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i),
        .lr_op_i(lr_op_i), .sc_op_i(sc_op_i), .store_op_i(store_op_i),
        .paddr_i(paddr_i), .inv_v_i(inv_v_i), .inv_addr_i(inv_addr_i),
        .inv_yumi_o(a_yumi), .sc_v_o(a_sc_v), .sc_success_o(a_sc_succ),
        .reservation_v_o(a_resv), .reservation_addr_o(a_addr)
    );

    bp_be_dcache_lrsc_monitor #(.paddr_width_p(PW), .block_offset_width_p(6), .lr_hold_p(0)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i),
        .lr_op_i(lr_op_i), .sc_op_i(sc_op_i), .store_op_i(store_op_i),
        .paddr_i(paddr_i), .inv_v_i(inv_v_i), .inv_addr_i(inv_addr_i),
        .inv_yumi_o(b_yumi), .sc_v_o(b_sc_v), .sc_success_o(b_sc_succ),
        .reservation_v_o(b_resv), .reservation_addr_o(b_addr)
    );

    always @(posedge clk) begin
        assert (!(v_i && lr_op_i && sc_op_i));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // SC result monitor for the hold-window instance.
    always @(negedge clk) begin
        if (a_sc_v === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sc_unexpected", 1, 0);
            end else begin
                chk("sc_success", a_sc_succ, exp_q.pop_front());
            end
        end
    end

    task automatic idle_in();
        reset_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; lr_op_i = 1'b0; sc_op_i = 1'b0;
        store_op_i = 1'b0; inv_v_i = 1'b0; paddr_i = '0; inv_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, lr, sc, st, fl, input logic [PW-1:0] pa,
                                input logic iv, input logic [PW-1:0] ia, input int reps,
                                input logic eyumi, eresv, input logic [LW-1:0] eaddr,
                                input logic esucc);
        vec_t t;
        t.v = v; t.lr = lr; t.sc = sc; t.st = st; t.fl = fl; t.pa = pa;
        t.iv = iv; t.ia = ia; t.reps = reps; t.exp_yumi = eyumi;
        t.exp_resv = eresv; t.exp_addr = eaddr; t.exp_succ = esucc;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //                  v  lr sc st fl  paddr      iv  inv_addr  reps yumi resv addr   succ
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0)); // LR -> HOLD
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    1, 40'h2000, 3,  1,   1,   34'h41, 0)); // other line accepted
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    1, 40'h1040, 13, 0,   1,   34'h41, 0)); // matching stalled
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    1, 40'h1040, 1,  1,   0,   34'h41, 0)); // RESERVED accepts
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1040, 0, 40'h0,    1,  0,   0,   34'h41, 0)); // SC after loss
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    0, 40'h0,    20, 0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1078, 0, 40'h0,    1,  0,   0,   34'h41, 1)); // basic pass
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1040, 0, 40'h0,    1,  0,   0,   34'h41, 1)); // SC in HOLD
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h2000, 0, 40'h0,    1,  0,   0,   34'h41, 0)); // SC wrong line
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 40'h1048, 0, 40'h0,    1,  0,   0,   34'h41, 0)); // store kills
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1040, 0, 40'h0,    1,  0,   0,   34'h41, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 40'h3000, 0, 40'h0,    1,  0,   1,   34'h41, 0)); // other store
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1040, 0, 40'h0,    1,  0,   0,   34'h41, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    0, 40'h0,    16, 0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 40'h1040, 1, 40'h1040, 1,  1,   0,   34'h41, 0)); // inv beats SC
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h1040, 0, 40'h0,    1,  0,   1,   34'h41, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    0, 40'h0,    16, 0,   1,   34'h41, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 40'h2000, 1, 40'h1040, 1,  1,   1,   34'h80, 0)); // LR + inv
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    1, 40'h2000, 1,  0,   1,   34'h80, 0)); // new HOLD
        vecs.push_back(mk(1, 0, 1, 1, 1, 40'h2000, 0, 40'h0,    1,  0,   0,   34'h80, 0)); // flush kills SC
        vecs.push_back(mk(1, 1, 0, 0, 1, 40'h1040, 0, 40'h0,    1,  0,   0,   34'h80, 0)); // flush kills LR
        vecs.push_back(mk(0, 0, 0, 0, 0, 40'h0,    1, 40'h1040, 1,  1,   0,   34'h80, 0)); // IDLE accepts

        idle_in();
        do_reset();
        chk("reset_sc_v", a_sc_v, 0);
        chk("reset_sc_success", a_sc_succ, 0);
        chk("reset_resv", a_resv, 0);
        chk("reset_addr", a_addr, 0);
        chk("reset_yumi", a_yumi, 0);
        chk("reset_b_resv", b_resv, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                v_i = vecs[i].v; lr_op_i = vecs[i].lr; sc_op_i = vecs[i].sc;
                store_op_i = vecs[i].st; flush_i = vecs[i].fl; paddr_i = vecs[i].pa;
                inv_v_i = vecs[i].iv; inv_addr_i = vecs[i].ia;
                #1;
                chk($sformatf("vec%0d_yumi", i), a_yumi, vecs[i].exp_yumi);
                if (vecs[i].v && vecs[i].sc && !vecs[i].fl) exp_q.push_back(vecs[i].exp_succ);
                tick();
                if (r == vecs[i].reps - 1) begin
                    chk($sformatf("vec%0d_resv", i), a_resv, vecs[i].exp_resv);
                    chk($sformatf("vec%0d_addr", i), a_addr, vecs[i].exp_addr);
                end
            end
        end
        idle_in();
        tick();
        chk("flush_no_sc_v", a_sc_v, 0);

        // Reset five cycles into the hold window.
        do_reset();
        v_i = 1'b1; lr_op_i = 1'b1; paddr_i = 40'h1040;
        tick();
        idle_in();
        repeat (5) tick();
        chk("mid_hold_resv", a_resv, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rst_hold_resv", a_resv, 0);
        chk("rst_hold_addr", a_addr, 0);
        chk("rst_hold_sc_v", a_sc_v, 0);

        // Reset in the same cycle as an SC drops its result.
        v_i = 1'b1; lr_op_i = 1'b1; paddr_i = 40'h1040;
        tick();
        lr_op_i = 1'b0; sc_op_i = 1'b1; store_op_i = 1'b1; reset_i = 1'b1;
        tick();
        idle_in();
        chk("rst_sc_dropped", a_sc_v, 0);
        chk("rst_sc_resv", a_resv, 0);

        // Zero-length hold window versus the 16-cycle one.
        do_reset();
        v_i = 1'b1; lr_op_i = 1'b1; paddr_i = 40'h1040;
        tick();
        idle_in();
        chk("h0_resv", b_resv, 1);
        chk("h0_addr", b_addr, 34'h41);
        inv_v_i = 1'b1; inv_addr_i = 40'h1070 + PW'($urandom_range(0, 15));
        #1;
        chk("h0_yumi", b_yumi, 1);
        chk("h16_yumi", a_yumi, 0);
        tick();
        idle_in();
        chk("h0_resv_after_inv", b_resv, 0);
        chk("h16_resv_after_inv", a_resv, 1);

        repeat (3) tick();
        chk("sc_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
